// File: rtl/mul_issue_pkg.sv
// Shared types and constants for the multiplier issue front-end.
package mul_issue_pkg;

    // Issue FSM state encoding
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } mul_state_t;

    localparam int unsigned OPND_W          = 8;
    localparam int unsigned PROD_W          = 16;
    localparam int unsigned MUL_LATENCY     = 4;
    localparam int unsigned DEFAULT_TIMEOUT = 8;

endpackage

// File: rtl/mul_req_fifo.sv
// Request FIFO: DEPTH entries of DATA_W bits, power-of-two depth, wrapping pointers.
module mul_req_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 20,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Storage array, written at the tail
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers and occupancy; push+pop together keeps the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mul_issue_ctrl.sv
// Multiplier request front-end: buffers requests, issues one at a time,
// returns tagged products with a watchdog-generated error on a missing done.
module mul_issue_ctrl
    import mul_issue_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OPND_W-1:0] req_a,
    input  logic [OPND_W-1:0] req_b,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [PROD_W-1:0] rsp_prod,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_err,
    output logic              mul_start,
    output logic [OPND_W-1:0] mul_a,
    output logic [OPND_W-1:0] mul_b,
    input  logic              mul_done,
    input  logic [PROD_W-1:0] mul_result,
    output logic              busy
);

    localparam int unsigned WD_W    = $clog2(TIMEOUT + 1);
    localparam int unsigned ENTRY_W = 2 * OPND_W + TAG_W;
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

    mul_state_t         state_q, state_d;
    logic [WD_W-1:0]    wd_q, wd_d, wd_inc;
    logic [OPND_W-1:0]  mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [TAG_W-1:0]   cur_tag_q, cur_tag_d;
    logic [PROD_W-1:0]  rsp_prod_q, rsp_prod_d;
    logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;
    logic               rsp_err_q, rsp_err_d;
    logic               rsp_valid_q, mul_start_q, busy_q;

    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ENTRY_W-1:0] fifo_rdata;
    logic [CNT_W-1:0]   fifo_count, fifo_cnt_d;

    assign req_ready = ~fifo_full;
    assign fifo_push = req_valid & req_ready;

    assign rsp_valid = rsp_valid_q;
    assign rsp_prod  = rsp_prod_q;
    assign rsp_tag   = rsp_tag_q;
    assign rsp_err   = rsp_err_q;
    assign mul_start = mul_start_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign busy      = busy_q;

    mul_req_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (ENTRY_W),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .wdata_i ({req_a, req_b, req_tag}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Next-state, pop and operand/response register updates
    always_comb begin
        state_d    = state_q;
        wd_d       = wd_q;
        wd_inc     = (wd_q == WD_W'(TIMEOUT)) ? wd_q : wd_q + WD_W'(1);
        fifo_pop   = 1'b0;
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
        cur_tag_d  = cur_tag_q;
        rsp_prod_d = rsp_prod_q;
        rsp_tag_d  = rsp_tag_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop                       = 1'b1;
                    {mul_a_d, mul_b_d, cur_tag_d}  = fifo_rdata;
                    state_d                        = S_START;
                end
            end
            S_START: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wd_d = wd_inc;
                if (mul_done) begin
                    rsp_prod_d = mul_result;
                    rsp_tag_d  = cur_tag_q;
                    rsp_err_d  = 1'b0;
                    state_d    = S_RESP;
                end else if (wd_inc == WD_W'(TIMEOUT)) begin
                    rsp_prod_d = '0;
                    rsp_tag_d  = cur_tag_q;
                    rsp_err_d  = 1'b1;
                    state_d    = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    if (!fifo_empty) begin
                        fifo_pop                       = 1'b1;
                        {mul_a_d, mul_b_d, cur_tag_d}  = fifo_rdata;
                        state_d                        = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO occupancy after this edge, for the registered busy flag
    always_comb begin
        fifo_cnt_d = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wd_q        <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            cur_tag_q   <= '0;
            rsp_prod_q  <= '0;
            rsp_tag_q   <= '0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            mul_start_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wd_q        <= wd_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            cur_tag_q   <= cur_tag_d;
            rsp_prod_q  <= rsp_prod_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_err_q   <= rsp_err_d;
            rsp_valid_q <= (state_d == S_RESP);
            mul_start_q <= (state_d == S_START);
            busy_q      <= (state_d != S_IDLE) || (fifo_cnt_d != '0);
        end
    end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Scoreboard bench for mul_issue_ctrl with a 4-cycle multiplier model.
module tb_mul_issue_ctrl;
    import mul_issue_pkg::*;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TAG_W   = 4;
    localparam int unsigned TIMEOUT = 8;

    logic              clk, rst_n;
    logic              req_valid, req_ready;
    logic [7:0]        req_a, req_b;
    logic [TAG_W-1:0]  req_tag;
    logic              rsp_valid, rsp_ready;
    logic [15:0]       rsp_prod;
    logic [TAG_W-1:0]  rsp_tag;
    logic              rsp_err;
    logic              mul_start, mul_done;
    logic [7:0]        mul_a, mul_b;
    logic [15:0]       mul_result;
    logic              busy;

    mul_issue_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_tag    (req_tag),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_prod   (rsp_prod),
        .rsp_tag    (rsp_tag),
        .rsp_err    (rsp_err),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_done   (mul_done),
        .mul_result (mul_result),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: fixed latency, done can be masked or forced
    logic [MUL_LATENCY-1:0] sr_q;
    logic [15:0]            rp_q [MUL_LATENCY];
    logic                   mul_en, stray;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
            for (int i = 0; i < MUL_LATENCY; i++) rp_q[i] <= '0;
        end else begin
            sr_q     <= {sr_q[MUL_LATENCY-2:0], mul_start};
            rp_q[0]  <= 16'(mul_a) * 16'(mul_b);
            for (int i = 1; i < MUL_LATENCY; i++) rp_q[i] <= rp_q[i-1];
        end
    end
    assign mul_done   = (sr_q[MUL_LATENCY-1] & mul_en) | stray;
    assign mul_result = rp_q[MUL_LATENCY-1];

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [15:0]      prod;
        logic             err;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        sb_e;
    int unsigned n_vec = 0, n_err = 0;
    int unsigned cyc = 0, n_rsp = 0, n_start = 0;
    int unsigned rsp_cyc_q[$];
    bit          saw_full = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor: pops the scoreboard on every accepted response
    always @(negedge clk) begin
        if (rst_n) begin
            if (mul_start) n_start++;
            if (!req_ready) saw_full = 1'b1;
            if (rsp_valid && rsp_ready) begin
                n_rsp++;
                rsp_cyc_q.push_back(cyc);
                if (sb_q.size() == 0) begin
                    chk("rsp_extra", 32'd1, 32'd0);
                end else begin
                    sb_e = sb_q.pop_front();
                    chk("rsp_prod", 32'(rsp_prod), 32'(sb_e.prod));
                    chk("rsp_tag",  32'(rsp_tag),  32'(sb_e.tag));
                    chk("rsp_err",  32'(rsp_err),  32'(sb_e.err));
                end
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [TAG_W-1:0] tag,
                        input logic [15:0] prod, input logic err);
        int   t;
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1; req_a = a; req_b = b; req_tag = tag;
        t = 0;
        while (!req_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            chk("req_accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        e.tag = tag; e.prod = prod; e.err = err;
        sb_q.push_back(e);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("drain", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({pfx, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({pfx, "_rsp_err"},   32'(rsp_err),   32'd0);
        chk({pfx, "_mul_start"}, 32'(mul_start), 32'd0);
        chk({pfx, "_busy"},      32'(busy),      32'd0);
        chk({pfx, "_rsp_prod"},  32'(rsp_prod),  32'd0);
        chk({pfx, "_rsp_tag"},   32'(rsp_tag),   32'd0);
        chk({pfx, "_mul_a"},     32'(mul_a),     32'd0);
        chk({pfx, "_mul_b"},     32'(mul_b),     32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int unsigned n, w, s0, r0, chg;
        logic [15:0] snap_prod;
        logic [TAG_W-1:0] snap_tag;
        logic snap_err;

        rst_n = 1'b0; rsp_ready = 1'b1; mul_en = 1'b1; stray = 1'b0;
        req_valid = 1'b0; req_a = '0; req_b = '0; req_tag = '0;
        #1 chk_reset("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single request: 6-cycle latency, one start pulse
        s0 = n_start;
        send(8'h0F, 8'h11, 4'd3, 16'h00FF, 1'b0);
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 50);
        chk("single_latency", 32'(n - 1), 32'd6);
        wait_drain();
        chk("single_starts", 32'(n_start - s0), 32'd1);

        // Five back-to-back requests
        repeat (3) @(negedge clk);
        saw_full = 1'b0;
        rsp_cyc_q.delete();
        send(8'hFF, 8'hFF, 4'd0, 16'hFE01, 1'b0);
        send(8'h00, 8'h55, 4'd1, 16'h0000, 1'b0);
        send(8'h01, 8'h01, 4'd2, 16'h0001, 1'b0);
        send(8'h80, 8'h02, 4'd3, 16'h0100, 1'b0);
        send(8'hAA, 8'h03, 4'd4, 16'h01FE, 1'b0);
        wait_drain();
        chk("b2b_full_seen", 32'(saw_full), 32'd1);
        chk("b2b_rsp_count", 32'(rsp_cyc_q.size()), 32'd5);
        for (int i = 1; i < 5; i++) begin
            if (rsp_cyc_q.size() == 5) chk("b2b_gap", rsp_cyc_q[i] - rsp_cyc_q[i-1], 32'd6);
        end

        // Backpressure: response held, FIFO fills
        repeat (3) @(negedge clk);
        rsp_ready = 1'b0;
        s0 = n_start;
        send(8'h12, 8'h34, 4'd5, 16'h03A8, 1'b0);
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 50);
        snap_prod = rsp_prod; snap_tag = rsp_tag; snap_err = rsp_err;
        send(8'h02, 8'h03, 4'd6, 16'h0006, 1'b0);
        send(8'h10, 8'h10, 4'd7, 16'h0100, 1'b0);
        send(8'hFF, 8'h01, 4'd8, 16'h00FF, 1'b0);
        send(8'h07, 8'h09, 4'd9, 16'h003F, 1'b0);
        chg = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_prod !== snap_prod || rsp_tag !== snap_tag || rsp_err !== snap_err)
                chg++;
        end
        chk("bp_hold_stable", chg, 32'd0);
        chk("bp_req_ready", 32'(req_ready), 32'd0);
        chk("bp_busy", 32'(busy), 32'd1);
        chk("bp_starts", 32'(n_start - s0), 32'd1);
        rsp_ready = 1'b1;
        wait_drain();

        // Watchdog: missing done gives error after 8 WAIT cycles
        repeat (3) @(negedge clk);
        mul_en = 1'b0;
        s0 = n_start;
        send(8'h05, 8'h06, 4'd10, 16'h0000, 1'b1);
        send(8'h05, 8'h06, 4'd11, 16'h001E, 1'b0);
        n = 0;
        do begin @(negedge clk); n++; end while (!mul_start && n < 50);
        w = 0;
        do begin @(negedge clk); w++; end while (!rsp_valid && w < 50);
        chk("wd_latency", w, 32'd9);
        mul_en = 1'b1;
        wait_drain();
        chk("wd_starts", 32'(n_start - s0), 32'd2);

        // Reset during WAIT with two queued
        repeat (3) @(negedge clk);
        send(8'h01, 8'h02, 4'd1, 16'h0002, 1'b0);
        send(8'h03, 8'h04, 4'd2, 16'h000C, 1'b0);
        send(8'h05, 8'h06, 4'd3, 16'h001E, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk_reset("mid");
        sb_q.delete();
        r0 = n_rsp; s0 = n_start;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("rst_no_rsp", n_rsp - r0, 32'd0);
        chk("rst_no_start", n_start - s0, 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);

        // Stray done in IDLE and in RESP
        r0 = n_rsp;
        @(negedge clk); stray = 1'b1;
        @(negedge clk); stray = 1'b0;
        @(negedge clk);
        chk("stray_idle_busy", 32'(busy), 32'd0);
        chk("stray_idle_valid", 32'(rsp_valid), 32'd0);
        rsp_ready = 1'b0;
        s0 = n_start;
        send(8'h09, 8'h09, 4'd12, 16'h0051, 1'b0);
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 50);
        stray = 1'b1;
        @(negedge clk); stray = 1'b0;
        @(negedge clk);
        chk("stray_resp_valid", 32'(rsp_valid), 32'd1);
        chk("stray_resp_prod", 32'(rsp_prod), 32'h51);
        chk("stray_resp_tag", 32'(rsp_tag), 32'd12);
        chk("stray_resp_starts", 32'(n_start - s0), 32'd1);
        rsp_ready = 1'b1;
        wait_drain();
        repeat (20) @(negedge clk);
        chk("stray_rsp_count", n_rsp - r0, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
